fetch_unit: RTL

//  IF stage of the Orion pipeline. Issues in-order word fetches to instruction memory over a req/gnt/rvalid interface.

---
 rtl/orion_types.sv | 30 +++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/orion_types.sv
// Shared Orion pipeline types: IF/ID record, instruction-memory request/response
// bundles and the architectural reset vector.
package orion_types;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] addr;
    } imem_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } imem_rsp_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, instr}. When empty, the head mirrors the
// write port so a push and pop in the same cycle passes straight through.
module fetch_fifo
    import orion_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_entry_t               wr_data,
    output fetch_entry_t               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          bypass;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = empty ? wr_data : mem[rd_ptr];
    assign bypass  = empty && push && pop;
    assign do_push = push && !bypass && (!full || pop);
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; count and pointers alone define which entries
    // are meaningful, and leaving data flops resetless keeps them plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Orion IF stage: credit-limited in-order word fetch, in-flight response tracking
// with wrong-path discard on redirect, and the IF/ID output register.
module fetch_unit
    import orion_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH   = 2,
    parameter int              MAX_INFLIGHT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output if_id_t          if_id_o
);
    localparam int CW  = $clog2(MAX_INFLIGHT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = ((CW > FCW) ? CW : FCW) + 1;

    logic [XLEN-1:0] fetch_pc, resp_pc, redirect_target;
    logic [CW-1:0]   inflight, discard_cnt, live;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_empty, fifo_full, fifo_push, fifo_pop, head_valid;
    logic            credit_ok, issue, rsp_ok;
    fetch_entry_t    head;
    imem_req_t       req;
    imem_rsp_t       rsp;

    assign rsp = '{gnt: imem_gnt_i, rvalid: imem_rvalid_i, rdata: imem_rdata_i};

    // Credit counts only live requests: discarded ones will never occupy the buffer.
    assign live      = inflight - discard_cnt;
    assign credit_ok = (SW'(live) + SW'(fifo_count) < SW'(FIFO_DEPTH)) &&
                       (inflight < CW'(MAX_INFLIGHT));
    assign req       = '{req: !rst_i && !redirect_valid_i && credit_ok, addr: fetch_pc};
    assign imem_req_o  = req.req;
    assign imem_addr_o = req.addr;

    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign issue      = req.req && rsp.gnt;
    assign rsp_ok     = rsp.rvalid && (inflight != '0);
    assign fifo_push  = rsp_ok && (discard_cnt == '0) && !redirect_valid_i;
    assign head_valid = !fifo_empty || fifo_push;
    assign fifo_pop   = !redirect_valid_i && !stall_i && head_valid;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (redirect_valid_i),
        .wr_data ('{pc: resp_pc, instr: rsp.rdata}),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            inflight    <= '0;
            discard_cnt <= '0;
        end else if (redirect_valid_i) begin
            // Everything still outstanding is wrong-path, including a response landing now.
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            inflight    <= inflight - CW'(rsp_ok);
            discard_cnt <= inflight - CW'(rsp_ok);
        end else begin
            if (issue)     fetch_pc <= fetch_pc + XLEN'(4);
            if (fifo_push) resp_pc  <= resp_pc + XLEN'(4);
            inflight <= inflight + CW'(issue) - CW'(rsp_ok);
            if (rsp_ok && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_o <= '0;
        end else if (redirect_valid_i) begin
            if_id_o.valid <= 1'b0;
        end else if (!stall_i) begin
            if (head_valid) if_id_o <= '{valid: 1'b1, pc: head.pc, instr: head.instr};
            else            if_id_o.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && imem_rvalid_i && inflight == '0)
            $error("fetch_unit: rvalid with no request in flight");
        if (!rst_i && fifo_push && fifo_full && !fifo_pop)
            $error("fetch_unit: instruction buffer overrun");
        if (!rst_i && redirect_valid_i && redirect_pc_i[1:0] != 2'b00)
            $warning("fetch_unit: misaligned redirect target %h", redirect_pc_i);
    end

endmodule
